// File: rtl/mem_ctrl_if.sv
// Bus bundle for mem_ctrl: fetch port, load/store port, byte-wide RAM port and status.
// master = requesters plus RAM model side, slave = the controller.
interface mem_ctrl_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_done;
    logic        mm_req;
    logic        mm_wr;
    logic [1:0]  mm_len;
    logic [31:0] mm_addr;
    logic [31:0] mm_wdata;
    logic [31:0] mm_rdata;
    logic        mm_done;
    logic [7:0]  ram_rn;
    logic [7:0]  ram_wn;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic        busy;
    logic [1:0]  state_dbg;

    modport master (
        output if_req, if_addr, mm_req, mm_wr, mm_len, mm_addr, mm_wdata, ram_rn,
        input  if_data, if_done, mm_rdata, mm_done, ram_wn, ram_a, ram_wr, busy, state_dbg
    );

    modport slave (
        input  if_req, if_addr, mm_req, mm_wr, mm_len, mm_addr, mm_wdata, ram_rn,
        output if_data, if_done, mm_rdata, mm_done, ram_wn, ram_a, ram_wr, busy, state_dbg
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: one fetch port and one load/store port sharing a synchronous byte RAM.
// Optional macro MEMCTRL_FAIR_ARB_EN selects round-robin tie arbitration (default: load/store wins ties).
module mem_ctrl (
    input  logic      clk,
    input  logic      rst,
    mem_ctrl_if.slave bus
);

    // Handshake: a requester raises *_req and holds it (with its operands) until its *_done
    // strobe; operands are latched at the grant edge, so dropping the request early never aborts.
    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_t;

    state_t      state;
    logic [2:0]  k;
    logic [2:0]  n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rbuf;
    logic        is_fetch;
`ifdef MEMCTRL_FAIR_ARB_EN
    logic        last_fetch;
`endif

    logic        grant_if;
    logic        grant_mm;
    logic [2:0]  k_nxt;
    logic [1:0]  byte_idx;
    logic [31:0] rd_word;

    always_comb begin
        grant_if = 1'b0;
        grant_mm = 1'b0;
        if (state == IDLE) begin
            if (bus.if_req && bus.mm_req) begin
`ifdef MEMCTRL_FAIR_ARB_EN
                grant_mm = last_fetch;
                grant_if = !last_fetch;
`else
                grant_mm = 1'b1;
`endif
            end else begin
                grant_if = bus.if_req;
                grant_mm = bus.mm_req;
            end
        end
    end

    // In RD, k counts addresses issued; the byte for address k-1 is on ram_rn this cycle.
    always_comb begin
        k_nxt    = k + 3'd1;
        byte_idx = 2'(k - 3'd1);
        rd_word  = rbuf | ({24'd0, bus.ram_rn} << {byte_idx, 3'b000});
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            k            <= 3'd0;
            n            <= 3'd0;
            addr         <= 32'd0;
            wdata        <= 32'd0;
            rbuf         <= 32'd0;
            is_fetch     <= 1'b0;
`ifdef MEMCTRL_FAIR_ARB_EN
            last_fetch   <= 1'b1;
`endif
            bus.ram_wr   <= 1'b0;
            bus.ram_a    <= 32'd0;
            bus.ram_wn   <= 8'd0;
            bus.if_done  <= 1'b0;
            bus.mm_done  <= 1'b0;
            bus.if_data  <= 32'd0;
            bus.mm_rdata <= 32'd0;
        end else begin
            bus.if_done <= 1'b0;
            bus.mm_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_if || grant_mm) begin
                        is_fetch <= grant_if;
                        k        <= 3'd0;
                        rbuf     <= 32'd0;
`ifdef MEMCTRL_FAIR_ARB_EN
                        last_fetch <= grant_if;
`endif
                        if (grant_if) begin
                            addr      <= bus.if_addr;
                            n         <= 3'd4;
                            bus.ram_a <= bus.if_addr;
                            state     <= RD;
                        end else begin
                            addr      <= bus.mm_addr;
                            n         <= {1'b0, bus.mm_len} + 3'd1;
                            wdata     <= bus.mm_wdata;
                            bus.ram_a <= bus.mm_addr;
                            if (bus.mm_wr) begin
                                bus.ram_wr <= 1'b1;
                                bus.ram_wn <= bus.mm_wdata[7:0];
                                state      <= WR;
                            end else begin
                                state <= RD;
                            end
                        end
                    end
                end
                RD: begin
                    if (k != 3'd0) rbuf <= rd_word;
                    if (k == n) begin
                        state     <= IDLE;
                        k         <= 3'd0;
                        bus.ram_a <= 32'd0;
                        if (is_fetch) begin
                            bus.if_data <= rd_word;
                            bus.if_done <= 1'b1;
                        end else begin
                            bus.mm_rdata <= rd_word;
                            bus.mm_done  <= 1'b1;
                        end
                    end else begin
                        k         <= k_nxt;
                        bus.ram_a <= (k_nxt < n) ? addr + {29'd0, k_nxt} : 32'd0;
                    end
                end
                WR: begin
                    if (k_nxt == n) begin
                        state       <= IDLE;
                        k           <= 3'd0;
                        bus.ram_wr  <= 1'b0;
                        bus.ram_a   <= 32'd0;
                        bus.ram_wn  <= 8'd0;
                        bus.mm_done <= 1'b1;
                    end else begin
                        k          <= k_nxt;
                        bus.ram_a  <= addr + {29'd0, k_nxt};
                        bus.ram_wn <= 8'(wdata >> {k_nxt[1:0], 3'b000});
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte RAM model, scoreboard of expected read words, tie and reset cases.
// Honors MEMCTRL_FAIR_ARB_EN for the expected tie order.
module tb_mem_ctrl;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    logic [31:0] exp_q[$];
    logic [31:0] ord_q[$];
    logic [31:0] last_if;
    logic [31:0] last_mm;

    logic [7:0] mem [0:1023] = '{256: 8'h13, 257: 8'h05, 258: 8'hA0, 259: 8'h00,
                                 514: 8'h5A, 1022: 8'h11, 1023: 8'h80,
                                 0: 8'h22, 1: 8'h33, default: 8'h00};

    mem_ctrl_if bus ();

    mem_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous byte RAM: address in cycle c, data in cycle c+1
    always @(posedge clk) begin
        if (bus.ram_wr) mem[bus.ram_a[9:0]] <= bus.ram_wn;
        bus.ram_rn <= mem[bus.ram_a[9:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic xfer(input bit fetch, input bit wr, input logic [1:0] len,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd);
        int n;
        int exp_c;
        bit seen;
        logic [31:0] got;
        n     = fetch ? 4 : int'(len) + 1;
        exp_c = wr ? n : n + 1;
        if (fetch) begin
            bus.if_req  = 1'b1;
            bus.if_addr = a;
        end else begin
            bus.mm_req   = 1'b1;
            bus.mm_wr    = wr;
            bus.mm_len   = len;
            bus.mm_addr  = a;
            bus.mm_wdata = wd;
        end
        if (!wr) exp_q.push_back(exp_rd);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (c < n) begin
                check("ram_a", bus.ram_a, a + 32'(c));
                check("ram_wr", {31'd0, bus.ram_wr}, {31'd0, wr});
                if (wr) check("ram_wn", {24'd0, bus.ram_wn}, (wd >> (8 * c)) & 32'hFF);
            end
            got = fetch ? bus.if_data : bus.mm_rdata;
            if ((fetch ? bus.if_done : bus.mm_done) === 1'b1) begin
                seen = 1'b1;
                bus.if_req = 1'b0;
                bus.mm_req = 1'b0;
                check("latency", 32'(c), 32'(exp_c));
                if (wr) begin
                    check("done_ram_wr", {31'd0, bus.ram_wr}, 32'd0);
                    check("done_ram_wn", {24'd0, bus.ram_wn}, 32'd0);
                end else begin
                    check("rdata", got, exp_q.pop_front());
                    if (fetch) last_if = exp_rd;
                    else       last_mm = exp_rd;
                end
            end else if (!wr) begin
                check("rdata_hold", got, fetch ? last_if : last_mm);
            end
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $error("FAIL timeout: got no done expected done");
            bus.if_req = 1'b0;
            bus.mm_req = 1'b0;
        end
    endtask

    initial begin
        int cnt;
        n_vec   = 0;
        n_err   = 0;
        last_if = 32'd0;
        last_mm = 32'd0;
        rst          = 1'b0;
        bus.if_req   = 1'b0;
        bus.if_addr  = 32'd0;
        bus.mm_req   = 1'b0;
        bus.mm_wr    = 1'b0;
        bus.mm_len   = 2'd0;
        bus.mm_addr  = 32'd0;
        bus.mm_wdata = 32'd0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_ram_wr", {31'd0, bus.ram_wr}, 32'd0);
        check("rst_ram_a", bus.ram_a, 32'd0);
        check("rst_ram_wn", {24'd0, bus.ram_wn}, 32'd0);
        check("rst_if_done", {31'd0, bus.if_done}, 32'd0);
        check("rst_mm_done", {31'd0, bus.mm_done}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_if_data", bus.if_data, 32'd0);
        check("rst_mm_rdata", bus.mm_rdata, 32'd0);

        // fetch right after reset release
        rst = 1'b1;
        xfer(1'b1, 1'b0, 2'd0, 32'h0000_0100, 32'd0, 32'h00A0_0513);

        // two-byte store, neighbour untouched
        xfer(1'b0, 1'b1, 2'd1, 32'h0000_0200, 32'hDEAD_BEEF, 32'd0);
        @(negedge clk);
        check("mem_200", {24'd0, mem[10'h200]}, 32'hEF);
        check("mem_201", {24'd0, mem[10'h201]}, 32'hBE);
        check("mem_202", {24'd0, mem[10'h202]}, 32'h5A);

        // loads: byte at top of memory, wrapping word, zero-extended half
        xfer(1'b0, 1'b0, 2'd0, 32'hFFFF_FFFF, 32'd0, 32'h0000_0080);
        xfer(1'b0, 1'b0, 2'd3, 32'hFFFF_FFFE, 32'd0, 32'h3322_8011);
        xfer(1'b0, 1'b0, 2'd1, 32'h0000_0101, 32'd0, 32'h0000_A005);

        // a fetch leaves mm_rdata alone
        xfer(1'b1, 1'b0, 2'd0, 32'h0000_03FE, 32'd0, 32'h3322_8011);
        check("mm_rdata_kept", bus.mm_rdata, 32'h0000_A005);

        // tie: both held across two transactions (1 = mm, 0 = fetch)
        @(negedge clk);
`ifdef MEMCTRL_FAIR_ARB_EN
        ord_q.push_back(32'd1); exp_q.push_back(32'h0000_0080);
        ord_q.push_back(32'd0); exp_q.push_back(32'h00A0_0513);
`else
        ord_q.push_back(32'd1); exp_q.push_back(32'h0000_0080);
        ord_q.push_back(32'd1); exp_q.push_back(32'h0000_0080);
`endif
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0100;
        bus.mm_req  = 1'b1;
        bus.mm_wr   = 1'b0;
        bus.mm_len  = 2'd0;
        bus.mm_addr = 32'hFFFF_FFFF;
        cnt = 0;
        for (int c = 0; c < 40 && cnt < 2; c++) begin
            @(negedge clk);
            if (bus.mm_done === 1'b1 || bus.if_done === 1'b1) begin
                if (ord_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $error("FAIL tie_extra: got extra done expected none");
                end else begin
                    check("tie_order", {31'd0, bus.mm_done}, ord_q.pop_front());
                    check("tie_data", bus.mm_done ? bus.mm_rdata : bus.if_data, exp_q.pop_front());
                end
                cnt++;
            end
            if (cnt == 2) begin
                bus.if_req = 1'b0;
                bus.mm_req = 1'b0;
            end
        end
        check("tie_count", 32'(cnt), 32'd2);
        bus.if_req = 1'b0;
        bus.mm_req = 1'b0;
        @(negedge clk);
        last_mm = 32'h0000_0080;
`ifdef MEMCTRL_FAIR_ARB_EN
        last_if = 32'h00A0_0513;
`endif

        // reset during cycle 2 of a word store
        bus.mm_req   = 1'b1;
        bus.mm_wr    = 1'b1;
        bus.mm_len   = 2'd3;
        bus.mm_addr  = 32'h0000_0300;
        bus.mm_wdata = 32'h1122_3344;
        repeat (3) @(negedge clk);
        check("pre_rst_ram_a", bus.ram_a, 32'h0000_0302);
        rst = 1'b0;
        #1;
        check("arst_ram_wr", {31'd0, bus.ram_wr}, 32'd0);
        check("arst_busy", {31'd0, bus.busy}, 32'd0);
        check("arst_ram_a", bus.ram_a, 32'd0);
        bus.mm_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("arst_no_done", {31'd0, bus.mm_done}, 32'd0);
        end
        check("mem_300", {24'd0, mem[10'h300]}, 32'h44);
        check("mem_301", {24'd0, mem[10'h301]}, 32'h33);
        check("mem_302", {24'd0, mem[10'h302]}, 32'h00);
        last_if = 32'd0;
        last_mm = 32'd0;
        rst = 1'b1;
        xfer(1'b1, 1'b0, 2'd0, 32'h0000_0100, 32'd0, 32'h00A0_0513);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
